// File: rtl/walkman_matrix.sv
// Pedestrian 8x8 LED matrix driver: row-scans a 4-frame walking-man animation,
// walking at double rate and blinking whole frames while the crossing time runs out.
module walkman_matrix #(
    parameter int SCAN_DIV  = 4096,
    parameter int BLANK_CYC = 256,
    parameter int FRAME_DIV = 64,
    parameter int HURRY_SEC = 5
) (
    input  logic       clksrc1_1,
    input  logic       reset,
    input  logic       greenmanon,
    input  logic [5:0] remaining,
    output logic [7:0] hori,
    output logic [7:0] vert,
    output logic [1:0] frame_idx
);
    localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SCAN_W = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0]  BLANK_END = PRE_W'(BLANK_CYC);
    localparam logic [SCAN_W-1:0] WALK_LIM  = SCAN_W'(FRAME_DIV - 1);
    localparam logic [SCAN_W-1:0] HURRY_LIM = SCAN_W'(FRAME_DIV / 2 - 1);
    localparam logic [5:0]        HURRY_THR = 6'(HURRY_SEC);

    typedef enum logic [1:0] {OFF, WALK, HURRY} state_t;

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [2:0]        row_q, row_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [1:0]        frame_q, frame_d;
    logic              blink_q, blink_d;
    logic [7:0]        hori_q, hori_d;
    logic [7:0]        vert_q, vert_d;

    logic              hurry_range;
    logic              row_tick;
    logic              frame_tick;
    logic              blank;
    logic [SCAN_W-1:0] scan_lim;
    logic [7:0]        row_sel;

    // Rows 0-4 (head, arms, torso) are shared; only the legs in rows 5-7 animate.
    function automatic logic [7:0] rom_row(input logic [1:0] f, input logic [2:0] r);
        logic [7:0] v;
        v = 8'h18;
        case (r)
            3'd2:       v = 8'h3C;
            3'd3:       v = 8'h5A;
            3'd5, 3'd6: begin
                case (f)
                    2'd0:    v = 8'h24;
                    2'd1:    v = 8'h28;
                    2'd2:    v = 8'h18;
                    default: v = 8'h14;
                endcase
            end
            3'd7: begin
                case (f)
                    2'd0:    v = 8'h42;
                    2'd1:    v = 8'h48;
                    2'd2:    v = 8'h18;
                    default: v = 8'h12;
                endcase
            end
            default:    v = 8'h18;
        endcase
        return v;
    endfunction

    always_comb begin
        hurry_range = (remaining != 6'd0) && (remaining <= HURRY_THR);
        state_d     = state_q;
        case (state_q)
            OFF:     if (greenmanon) state_d = hurry_range ? HURRY : WALK;
            WALK:    if (hurry_range) state_d = HURRY;
            HURRY:   if (remaining > HURRY_THR) state_d = WALK;
            default: state_d = OFF;
        endcase
        if (!greenmanon) state_d = OFF;
    end

    always_comb begin
        scan_lim   = (state_q == HURRY) ? HURRY_LIM : WALK_LIM;
        row_tick   = (state_q != OFF) && (pre_q == PRE_MAX);
        frame_tick = row_tick && (row_q == 3'd7) && (scan_q >= scan_lim);
        pre_d      = pre_q;
        row_d      = row_q;
        scan_d     = scan_q;
        frame_d    = frame_q;
        blink_d    = blink_q;
        if (state_q != OFF) begin
            pre_d = row_tick ? '0 : PRE_W'(pre_q + 1);
            if (row_tick) row_d = row_q + 3'd1;
            if (frame_tick) begin
                scan_d  = '0;
                frame_d = frame_q + 2'd1;
            end else if (row_tick && row_q == 3'd7) begin
                scan_d = SCAN_W'(scan_q + 1);
            end
            if (frame_tick && state_q == HURRY) blink_d = ~blink_q;
        end
        if (state_q == HURRY && state_d == WALK) blink_d = 1'b0;
        if (state_d == HURRY && scan_d > HURRY_LIM) scan_d = HURRY_LIM;
        if (state_d == OFF) begin
            pre_d   = '0;
            row_d   = '0;
            scan_d  = '0;
            frame_d = '0;
            blink_d = 1'b0;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_row_sel
        assign row_sel[gi] = (row_q == 3'(gi));
    end

    // A dropping greenmanon blanks the very next output rather than one row-sample later.
    always_comb begin
        blank  = (state_q == OFF) || (state_d == OFF) || (pre_q < BLANK_END) ||
                 ((state_q == HURRY) && blink_q);
        hori_d = blank ? 8'h00 : rom_row(frame_q, row_q);
        vert_d = blank ? 8'h00 : row_sel;
    end

    always_ff @(posedge clksrc1_1) begin
        if (reset) begin
            state_q <= OFF;
            pre_q   <= '0;
            row_q   <= '0;
            scan_q  <= '0;
            frame_q <= '0;
            blink_q <= 1'b0;
            hori_q  <= 8'h00;
            vert_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            row_q   <= row_d;
            scan_q  <= scan_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            hori_q  <= hori_d;
            vert_q  <= vert_d;
        end
    end

    assign hori      = hori_q;
    assign vert      = vert_q;
    assign frame_idx = frame_q;
endmodule

// File: tb/tb_walkman_matrix.sv
// Directed bench for walkman_matrix with a small scan configuration; expected
// values are hand-derived cycle positions in the scan/animation sequence.
module tb_walkman_matrix;
    logic       clk = 1'b0;
    logic       rst;
    logic       green;
    logic [5:0] rem;
    logic [7:0] hori;
    logic [7:0] vert;
    logic [1:0] frame;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int base   = 0;

    typedef struct {
        logic       green;
        logic [5:0] rem;
        logic [7:0] hori;
        logic [7:0] vert;
        logic [1:0] frame;
    } vec_t;

    vec_t vecs [12];

    walkman_matrix #(
        .SCAN_DIV (8),
        .BLANK_CYC(2),
        .FRAME_DIV(4),
        .HURRY_SEC(5)
    ) dut (
        .clksrc1_1 (clk),
        .reset     (rst),
        .greenmanon(green),
        .remaining (rem),
        .hori      (hori),
        .vert      (vert),
        .frame_idx (frame)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int k);
        while (cyc - base < k) step();
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h (cycle %0d)", name, act, exp, cyc - base);
        end else begin
            $display("ok   %s: %02h (cycle %0d)", name, act, cyc - base);
        end
    endtask

    task automatic chk_out(input string name, input logic [7:0] h, input logic [7:0] v);
        chk({name, ".hori"}, hori, h);
        chk({name, ".vert"}, vert, v);
    endtask

    initial begin
        // First row period after entering WALK: entry + 2 blank, 6 lit, 2 blank, next row.
        for (int i = 0; i < 12; i++) vecs[i] = '{1'b1, 6'd15, 8'h00, 8'h00, 2'd0};
        for (int i = 3; i < 9; i++) begin
            vecs[i].hori = 8'h18;
            vecs[i].vert = 8'h01;
        end
        vecs[11].hori = 8'h18;
        vecs[11].vert = 8'h02;

        // Reset held with greenmanon high
        rst   = 1'b1;
        green = 1'b1;
        rem   = 6'd15;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("reset", 8'h00, 8'h00);
            chk("reset.frame", {6'd0, frame}, 8'h00);
        end

        rst  = 1'b0;
        base = cyc;
        for (int i = 0; i < 12; i++) begin
            green = vecs[i].green;
            rem   = vecs[i].rem;
            step();
            chk_out($sformatf("entry[%0d]", i), vecs[i].hori, vecs[i].vert);
            chk($sformatf("entry[%0d].frame", i), {6'd0, frame}, {6'd0, vecs[i].frame});
        end

        // WALK animation: 256 cycles per frame
        goto(256);  chk("walk.frame0", {6'd0, frame}, 8'h00);
        goto(257);  chk("walk.frame1", {6'd0, frame}, 8'h01);
        goto(300);  chk_out("walk.f1row5", 8'h28, 8'h20);
        goto(828);  chk_out("walk.f3row7", 8'h12, 8'h80);
        goto(1024); chk("walk.frame3", {6'd0, frame}, 8'h03);
        goto(1025); chk("walk.wrap", {6'd0, frame}, 8'h00);

        // HURRY: 128 cycles per frame, odd frames blanked
        rem = 6'd5;
        goto(1152); chk("hurry.frame0", {6'd0, frame}, 8'h00);
        goto(1153); chk("hurry.frame1", {6'd0, frame}, 8'h01);
        chk_out("hurry.f0row7", 8'h42, 8'h80);
        goto(1200); chk_out("hurry.blink", 8'h00, 8'h00);
        goto(1281); chk("hurry.frame2", {6'd0, frame}, 8'h02);
        goto(1284); chk_out("hurry.unblink", 8'h18, 8'h01);

        // Back to WALK, then greenmanon drops at pre=5, row=3
        goto(1289);
        rem = 6'd15;
        goto(1310); chk_out("drop.before", 8'h5A, 8'h08);
        green = 1'b0;
        step();
        chk_out("drop.next", 8'h00, 8'h00);
        chk("drop.frame", {6'd0, frame}, 8'h00);
        step();
        chk_out("drop.off", 8'h00, 8'h00);
        green = 1'b1;
        base  = cyc;
        goto(3); chk_out("reentry.blank", 8'h00, 8'h00);
        goto(4); chk_out("reentry.row0", 8'h18, 8'h01);
        chk("reentry.frame", {6'd0, frame}, 8'h00);

        // remaining==0 stays in WALK
        green = 1'b0;
        step();
        step();
        green = 1'b1;
        rem   = 6'd0;
        base  = cyc;
        goto(129); chk("zero.frame", {6'd0, frame}, 8'h00);
        goto(132); chk_out("zero.lit", 8'h18, 8'h01);
        goto(257); chk("zero.frame1", {6'd0, frame}, 8'h01);

        // HURRY with blink set, then reset
        rem = 6'd3;
        goto(384); chk("blink.frame1", {6'd0, frame}, 8'h01);
        goto(385); chk("blink.frame2", {6'd0, frame}, 8'h02);
        goto(390); chk_out("blink.on", 8'h00, 8'h00);
        rst = 1'b1;
        step();
        chk_out("rst.hurry", 8'h00, 8'h00);
        chk("rst.frame", {6'd0, frame}, 8'h00);
        step();
        rst  = 1'b0;
        base = cyc;
        goto(3);   chk_out("rst.reentry.blank", 8'h00, 8'h00);
        goto(4);   chk_out("rst.blink_clear", 8'h18, 8'h01);
        goto(128); chk("rst.hurry.frame0", {6'd0, frame}, 8'h00);
        goto(129); chk("rst.hurry.frame1", {6'd0, frame}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
